// File: rtl/reindeer_mem_arbiter.sv
// reindeer_mem_arbiter: shares one memory port between the instruction-fetch
// and data load/store requesters, with at most one transaction outstanding.
// Each requester has a holding register and a pending flag. Ties go to the port
// not granted last. A wait counter abandons a transaction that never completes.
module reindeer_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_done,
    output logic [XLEN-1:0]   fetch_rdata,
    output logic              fetch_busy,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [XLEN-1:0]   data_wdata,
    input  logic [XLEN/8-1:0] data_be,
    output logic              data_done,
    output logic [XLEN-1:0]   data_rdata,
    output logic              data_busy,
    output logic              err,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_done,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_last_data;     // 1 = data port was granted last
    logic [CNT_W-1:0]  r_cnt;

    logic              r_fetch_pend;
    logic              r_data_pend;
    logic              r_fetch_flight;
    logic              r_data_flight;
    logic              r_fetch_busy;
    logic              r_data_busy;

    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_data_addr;
    logic [XLEN-1:0]   r_data_wdata;
    logic [BE_W-1:0]   r_data_be;
    logic              r_data_we;

    logic              r_fetch_done;
    logic              r_data_done;
    logic              r_err;
    logic [XLEN-1:0]   r_fetch_rdata;
    logic [XLEN-1:0]   r_data_rdata;

    logic              r_mem_enable;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;

    logic              w_idle;
    logic              w_fetch_acc;
    logic              w_data_acc;
    logic              w_fetch_elig;
    logic              w_data_elig;
    logic              w_grant_data;
    logic              w_grant_fetch;
    logic [ADDR_W-1:0] w_fetch_addr_sel;
    logic [ADDR_W-1:0] w_data_addr_sel;
    logic [XLEN-1:0]   w_data_wdata_sel;
    logic [BE_W-1:0]   w_data_be_sel;
    logic              w_data_we_sel;
    logic              w_mem_done_ok;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_timeout;
    logic              w_finish;

    assign w_idle = (r_state == S_IDLE);

    // A request is taken only while its port reads not-busy; otherwise it is dropped.
    assign w_fetch_acc  = fetch_req & ~r_fetch_busy;
    assign w_data_acc   = data_req  & ~r_data_busy;
    assign w_fetch_elig = r_fetch_pend | w_fetch_acc;
    assign w_data_elig  = r_data_pend  | w_data_acc;

    // Data wins when it is alone, or on a tie after a fetch grant.
    assign w_grant_data  = w_idle & w_data_elig & (~w_fetch_elig | ~r_last_data);
    assign w_grant_fetch = w_idle & w_fetch_elig & ~w_grant_data;

    // A request accepted this cycle is granted straight from the ports,
    // because its holding register only loads at the coming edge.
    assign w_fetch_addr_sel = r_fetch_pend ? r_fetch_addr : fetch_addr;
    assign w_data_addr_sel  = r_data_pend  ? r_data_addr  : data_addr;
    assign w_data_wdata_sel = r_data_pend  ? r_data_wdata : data_wdata;
    assign w_data_be_sel    = r_data_pend  ? r_data_be    : data_be;
    assign w_data_we_sel    = r_data_pend  ? r_data_we    : data_we;

    // mem_done coincident with the enable strobe, or outside S_WAIT, is ignored.
    assign w_mem_done_ok = ~w_idle & ~r_mem_enable & mem_done;
    assign w_cnt_next    = r_cnt + CNT_W'(1);
    assign w_timeout     = ~w_idle & ~w_mem_done_ok & (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));
    assign w_finish      = w_mem_done_ok | w_timeout;

    // Pending flags and the registered busy indication for both ports.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_pend <= 1'b0;
            r_data_pend  <= 1'b0;
            r_fetch_busy <= 1'b0;
            r_data_busy  <= 1'b0;
        end else begin
            if (w_fetch_acc)   r_fetch_pend <= 1'b1;
            if (w_grant_fetch) r_fetch_pend <= 1'b0;
            if (w_data_acc)    r_data_pend  <= 1'b1;
            if (w_grant_data)  r_data_pend  <= 1'b0;
            // Busy stays high through the done cycle and drops one cycle later.
            r_fetch_busy <= w_fetch_acc | r_fetch_pend | r_fetch_flight;
            r_data_busy  <= w_data_acc  | r_data_pend  | r_data_flight;
        end
    end

    // Holding registers capture the request fields when a request is accepted.
    always_ff @(posedge clk) begin
        if (w_fetch_acc) begin
            r_fetch_addr <= fetch_addr;
        end
        if (w_data_acc) begin
            r_data_addr  <= data_addr;
            r_data_wdata <= data_wdata;
            r_data_be    <= data_be;
            r_data_we    <= data_we;
        end
    end

    // Arbitration FSM: issues one memory transaction and waits for completion or timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_last_data    <= 1'b0;
            r_cnt          <= '0;
            r_fetch_flight <= 1'b0;
            r_data_flight  <= 1'b0;
            r_mem_enable   <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_be       <= '0;
        end else begin
            r_mem_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_data) begin
                        r_state       <= S_WAIT;
                        r_mem_enable  <= 1'b1;
                        r_mem_we      <= w_data_we_sel;
                        r_mem_addr    <= w_data_addr_sel;
                        r_mem_wdata   <= w_data_wdata_sel;
                        r_mem_be      <= w_data_be_sel;
                        r_data_flight <= 1'b1;
                        r_last_data   <= 1'b1;
                        r_cnt         <= '0;
                    end else if (w_grant_fetch) begin
                        r_state        <= S_WAIT;
                        r_mem_enable   <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= w_fetch_addr_sel;
                        r_mem_be       <= '1;
                        r_fetch_flight <= 1'b1;
                        r_last_data    <= 1'b0;
                        r_cnt          <= '0;
                    end
                end
                S_WAIT: begin
                    // The timeout fires at the end of the TIMEOUT_CYCLES-th waiting
                    // cycle and then finishes just like a mem_done in that cycle.
                    if (w_finish) begin
                        r_state        <= S_IDLE;
                        r_fetch_flight <= 1'b0;
                        r_data_flight  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Completion pulses, timeout flag and per-port read data capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_done  <= 1'b0;
            r_data_done   <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_fetch_done <= w_finish & r_fetch_flight;
            r_data_done  <= w_finish & r_data_flight;
            r_err        <= w_timeout;
            if (w_mem_done_ok & r_fetch_flight) begin
                r_fetch_rdata <= mem_rdata;
            end
            // A store completion leaves the previous load data in place.
            if (w_mem_done_ok & r_data_flight & ~r_mem_we) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    assign fetch_done  = r_fetch_done;
    assign fetch_rdata = r_fetch_rdata;
    assign fetch_busy  = r_fetch_busy;
    assign data_done   = r_data_done;
    assign data_rdata  = r_data_rdata;
    assign data_busy   = r_data_busy;
    assign err         = r_err;
    assign mem_enable  = r_mem_enable;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;

endmodule

// File: tb/tb_reindeer_mem_arbiter.sv
// Testbench for reindeer_mem_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_reindeer_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int XLEN   = 32;
    localparam int BE_W   = XLEN / 8;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_done;
    logic [XLEN-1:0]   fetch_rdata;
    logic              fetch_busy;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [XLEN-1:0]   data_wdata;
    logic [BE_W-1:0]   data_be;
    logic              data_done;
    logic [XLEN-1:0]   data_rdata;
    logic              data_busy;
    logic              err;
    logic              mem_enable;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_done;
    logic [XLEN-1:0]   mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (transaction level).
    bit              m_f_out, m_d_out;       // request issued, completion not yet seen
    bit              m_f_cand, m_d_cand;     // request waiting for a grant
    bit              m_inflight, m_inf_data, m_last_data, m_exp_en;
    bit              m_jd_f, m_jd_d, m_tx_we, m_done_err, m_d_we;
    logic [31:0]     m_f_addr, m_d_addr, m_d_wdata, m_tx_addr, m_tx_wdata;
    logic [31:0]     m_f_rd, m_d_rd, m_resp;
    logic [3:0]      m_d_be, m_tx_be;
    int              m_done_due, m_mem_done_at, lat, n_en;
    bit              pick_data, en_now, fd, dd, er;

    reindeer_mem_arbiter #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .fetch_rdata(fetch_rdata), .fetch_busy(fetch_busy),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be), .data_done(data_done),
        .data_rdata(data_rdata), .data_busy(data_busy), .err(err),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_done(mem_done),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".fetch_done"}, fetch_done, 0);
        chk({tag, ".data_done"}, data_done, 0);
        chk({tag, ".fetch_busy"}, fetch_busy, 0);
        chk({tag, ".data_busy"}, data_busy, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".mem_enable"}, mem_enable, 0);
        chk({tag, ".mem_we"}, mem_we, 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".mem_be"}, mem_be, 0);
        chk({tag, ".fetch_rdata"}, fetch_rdata, 0);
        chk({tag, ".data_rdata"}, data_rdata, 0);
    endtask

    // Called in the mem_enable cycle; answers one cycle later and returns in the done cycle.
    task automatic serve(input logic [XLEN-1:0] rd);
        step();
        mem_done  = 1'b1;
        mem_rdata = rd;
        step();
        mem_done  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0;
        data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
        mem_done = 1'b0; mem_rdata = '0;
        step(); step();
        chk_quiet("reset");
        reset_n = 1'b1;
        step();

        // Single fetch: request in cycle 0, mem_done in cycle 3.
        fetch_req = 1'b1; fetch_addr = 32'h100;
        step();                                   // cycle 1
        fetch_req = 1'b0;
        chk("single.mem_enable", mem_enable, 1);
        chk("single.mem_we", mem_we, 0);
        chk("single.mem_be", mem_be, 4'hF);
        chk("single.mem_addr", mem_addr, 32'h100);
        chk("single.busy_c1", fetch_busy, 1);
        step();                                   // cycle 2
        chk("single.enable_c2", mem_enable, 0);
        chk("single.busy_c2", fetch_busy, 1);
        step();                                   // cycle 3
        chk("single.busy_c3", fetch_busy, 1);
        mem_done = 1'b1; mem_rdata = 32'h0000_0013;
        step();                                   // cycle 4
        mem_done = 1'b0;
        chk("single.fetch_done", fetch_done, 1);
        chk("single.fetch_rdata", fetch_rdata, 32'h13);
        chk("single.busy_c4", fetch_busy, 1);
        chk("single.err", err, 0);
        chk("single.data_done", data_done, 0);
        step();                                   // cycle 5
        chk("single.done_c5", fetch_done, 0);
        chk("single.busy_c5", fetch_busy, 0);

        // Simultaneous requests right after reset: data wins the first tie.
        reset_n = 1'b0; step(); reset_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h400;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h200;
        data_wdata = 32'hDEAD_BEEF; data_be = 4'h3;
        step();
        fetch_req = 1'b0; data_req = 1'b0;
        chk("tie1.mem_enable", mem_enable, 1);
        chk("tie1.mem_addr", mem_addr, 32'h200);
        chk("tie1.mem_we", mem_we, 1);
        chk("tie1.mem_be", mem_be, 4'h3);
        chk("tie1.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        serve(32'h5555_5555);
        chk("tie1.data_done", data_done, 1);
        chk("tie1.fetch_done", fetch_done, 0);
        chk("tie1.store_keeps_rdata", data_rdata, 0);
        step();
        chk("tie2.mem_enable", mem_enable, 1);
        chk("tie2.mem_addr", mem_addr, 32'h400);
        chk("tie2.mem_we", mem_we, 0);
        chk("tie2.mem_be", mem_be, 4'hF);
        serve(32'h0000_0093);
        chk("tie2.fetch_done", fetch_done, 1);
        chk("tie2.fetch_rdata", fetch_rdata, 32'h93);
        chk("tie2.data_done", data_done, 0);
        step();
        chk("tie3.fetch_busy_low", fetch_busy, 0);
        chk("tie3.data_busy_low", data_busy, 0);
        fetch_req = 1'b1; fetch_addr = 32'h404;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h204;
        step();
        fetch_req = 1'b0; data_req = 1'b0;
        chk("tie3.mem_enable", mem_enable, 1);
        chk("tie3.mem_addr", mem_addr, 32'h204);
        chk("tie3.mem_we", mem_we, 0);
        serve(32'hCAFE_F00D);
        chk("tie3.data_done", data_done, 1);
        chk("tie3.data_rdata", data_rdata, 32'hCAFE_F00D);
        step();
        chk("tie3.fetch_enable", mem_enable, 1);
        chk("tie3.fetch_addr", mem_addr, 32'h404);
        serve(32'h1357_9BDF);
        chk("tie3.fetch_rdata", fetch_rdata, 32'h1357_9BDF);
        step();

        // Overrun: a second fetch request while busy is dropped.
        fetch_req = 1'b1; fetch_addr = 32'h180;
        step();                                   // c1
        fetch_req = 1'b1; fetch_addr = 32'h300;
        n_en = int'(mem_enable);
        chk("ovr.addr_c1", mem_addr, 32'h180);
        step();                                   // c2
        fetch_req = 1'b0;
        n_en += int'(mem_enable);
        chk("ovr.addr_c2", mem_addr, 32'h180);
        step();                                   // c3
        n_en += int'(mem_enable);
        chk("ovr.addr_c3", mem_addr, 32'h180);
        mem_done = 1'b1; mem_rdata = 32'h1111_2222;
        step();                                   // c4
        mem_done = 1'b0;
        chk("ovr.fetch_done", fetch_done, 1);
        chk("ovr.fetch_rdata", fetch_rdata, 32'h1111_2222);
        for (int i = 0; i < 6; i++) begin
            step();
            n_en += int'(mem_enable);
        end
        chk("ovr.enable_count", n_en, 1);

        // Timeout: a data load whose mem_done never arrives.
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h240;
        step();
        data_req = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        chk("tmo.mem_enable", mem_enable, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("tmo.early_done", data_done, 0);
            chk("tmo.early_err", err, 0);
        end
        step();
        chk("tmo.data_done", data_done, 1);
        chk("tmo.err", err, 1);
        chk("tmo.fetch_done", fetch_done, 0);
        chk("tmo.data_rdata", data_rdata, 32'hCAFE_F00D);
        step();
        chk("tmo.done_after", data_done, 0);
        chk("tmo.err_after", err, 0);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        chk("tmo.late_done", data_done, 0);
        chk("tmo.late_err", err, 0);
        chk("tmo.late_rdata", data_rdata, 32'hCAFE_F00D);
        chk("tmo.late_enable", mem_enable, 0);

        // Reset in the middle of a transaction.
        fetch_req = 1'b1; fetch_addr = 32'h500;
        step();
        fetch_req = 1'b0;
        chk("rst2.mem_enable", mem_enable, 1);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk_quiet("rst2");
        mem_done = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_done = 1'b0;
        chk_quiet("rst2.late");
        fetch_req = 1'b1; fetch_addr = 32'h504;
        step();
        fetch_req = 1'b0;
        chk("rst2.fresh_enable", mem_enable, 1);
        chk("rst2.fresh_addr", mem_addr, 32'h504);
        chk("rst2.fresh_we", mem_we, 0);
        serve(32'h2468_ACE0);
        chk("rst2.fresh_done", fetch_done, 1);
        chk("rst2.fresh_rdata", fetch_rdata, 32'h2468_ACE0);
        step();

        // Randomized traffic against the reference model.
        reset_n = 1'b0; step(); reset_n = 1'b1;
        m_f_out = 0; m_d_out = 0; m_f_cand = 0; m_d_cand = 0;
        m_inflight = 0; m_inf_data = 0; m_last_data = 0; m_exp_en = 0;
        m_f_rd = '0; m_d_rd = '0; m_resp = '0;
        m_done_due = -1; m_mem_done_at = -1; m_done_err = 0;
        m_tx_addr = '0; m_tx_we = 0; m_tx_be = '0; m_tx_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_jd_f = 0; m_jd_d = 0;
            en_now = m_exp_en;
            chk("rnd.mem_enable", mem_enable, en_now);
            if (en_now) begin
                chk("rnd.mem_addr", mem_addr, m_tx_addr);
                chk("rnd.mem_we", mem_we, m_tx_we);
                chk("rnd.mem_be", mem_be, m_tx_be);
                if (m_inf_data && m_tx_we) chk("rnd.mem_wdata", mem_wdata, m_tx_wdata);
                if ($urandom_range(7) == 0) begin
                    m_done_due = cyc + TMO; m_done_err = 1; m_mem_done_at = -1;
                end else begin
                    lat = int'($urandom_range(3, 1));
                    m_mem_done_at = cyc + lat; m_done_due = cyc + lat + 1; m_done_err = 0;
                end
            end
            fd = (m_done_due == cyc) && !m_inf_data;
            dd = (m_done_due == cyc) && m_inf_data;
            er = (m_done_due == cyc) && m_done_err;
            chk("rnd.fetch_done", fetch_done, fd);
            chk("rnd.data_done", data_done, dd);
            chk("rnd.err", err, er);
            chk("rnd.fetch_busy", fetch_busy, m_f_out);
            chk("rnd.data_busy", data_busy, m_d_out);
            if (m_done_due == cyc) begin
                if (!m_done_err) begin
                    if (!m_inf_data) m_f_rd = m_resp;
                    else if (!m_tx_we) m_d_rd = m_resp;
                end
                m_inflight = 0;
                if (m_inf_data) begin m_d_out = 0; m_jd_d = 1; end
                else begin m_f_out = 0; m_jd_f = 1; end
                m_done_due = -1;
            end
            chk("rnd.fetch_rdata", fetch_rdata, m_f_rd);
            chk("rnd.data_rdata", data_rdata, m_d_rd);

            fetch_req = 1'b0; data_req = 1'b0; mem_done = 1'b0;
            mem_rdata = $urandom();
            if (cyc == m_mem_done_at) begin
                mem_done = 1'b1; m_resp = mem_rdata;
            end else if (!m_inflight && $urandom_range(5) == 0) begin
                mem_done = 1'b1;
            end else if (en_now && $urandom_range(3) == 0) begin
                mem_done = 1'b1;
            end
            if (!m_f_out && !m_jd_f && $urandom_range(2) == 0) begin
                fetch_req = 1'b1; fetch_addr = {4'h1, 26'($urandom()), 2'b00};
                m_f_out = 1; m_f_cand = 1; m_f_addr = fetch_addr;
            end else if ((m_f_out || m_jd_f) && $urandom_range(4) == 0) begin
                fetch_req = 1'b1; fetch_addr = $urandom();
            end
            if (!m_d_out && !m_jd_d && $urandom_range(2) == 0) begin
                data_req = 1'b1; data_we = 1'($urandom());
                data_addr = {4'h8, 26'($urandom()), 2'b00};
                data_wdata = $urandom(); data_be = 4'($urandom());
                m_d_out = 1; m_d_cand = 1; m_d_addr = data_addr;
                m_d_we = data_we; m_d_wdata = data_wdata; m_d_be = data_be;
            end else if ((m_d_out || m_jd_d) && $urandom_range(4) == 0) begin
                data_req = 1'b1; data_we = 1'($urandom()); data_addr = $urandom();
                data_wdata = $urandom(); data_be = 4'($urandom());
            end
            m_exp_en = 0;
            if (!m_inflight && (m_f_cand || m_d_cand)) begin
                pick_data = m_d_cand && (!m_f_cand || !m_last_data);
                m_exp_en = 1; m_inflight = 1; m_inf_data = pick_data; m_last_data = pick_data;
                if (pick_data) begin
                    m_tx_addr = m_d_addr; m_tx_we = m_d_we; m_tx_be = m_d_be;
                    m_tx_wdata = m_d_wdata; m_d_cand = 0;
                end else begin
                    m_tx_addr = m_f_addr; m_tx_we = 0; m_tx_be = 4'hF; m_f_cand = 0;
                end
            end
            step();
        end
        fetch_req = 1'b0; data_req = 1'b0; mem_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reindeer_mem_arbiter.md
REINDEER_MEM_ARBITER -- requirements
Module: reindeer_mem_arbiter

Interface
REQ-001 Parameters SHALL be as follows.
- ADDR_W, 32: address width.
- XLEN, 32: data width; byte-enable width = XLEN/8.
- TIMEOUT_CYCLES, 255: maximum wait for mem_done; range 2..255.

REQ-002 The block SHALL use one clock and a synchronous, active-low reset. Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- fetch_req  in  1  one-cycle read request from instruction fetch.
- fetch_addr  in  ADDR_W  fetch address; sampled with fetch_req.
- fetch_done  out  1  one-cycle completion pulse.
- fetch_rdata  out  XLEN  fetched word; valid with fetch_done.
- fetch_busy  out  1  fetch request pending or in flight.
- data_req  in  1  one-cycle load/store request.
- data_we  in  1  1 = store; sampled with data_req.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  XLEN  store data.
- data_be  in  XLEN/8  store byte enables.
- data_done  out  1  one-cycle completion pulse.
- data_rdata  out  XLEN  load data; valid with data_done.
- data_busy  out  1  data request pending or in flight.
- err  out  1  timeout flag; pulses together with the failing port's done pulse.
- mem_enable  out  1  one-cycle transaction strobe to the memory controller.
- mem_we  out  1  write qualifier.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  XLEN  write data.
- mem_be  out  XLEN/8  byte enables.
- mem_done  in  1  completion pulse from the memory controller.
- mem_rdata  in  XLEN  read data; valid with mem_done.

Function
REQ-003 The block SHALL share a single memory port between the fetch and data requesters, with at most one transaction outstanding.
REQ-004 On each req pulse, the block SHALL latch that port's address, write data, byte enables and we into per-port holding registers, and set the port's pending flag.
REQ-005 A req on a port whose busy output is already high SHALL be ignored; the holding registers and the pending flag SHALL remain unchanged.
REQ-006 busy SHALL be the registered value of (pending or in flight), so it goes high the cycle after the req pulse.
REQ-007 The FSM SHALL have two states, S_IDLE and S_WAIT, with S_IDLE as the reset state.
REQ-008 In S_IDLE, if any pending flag is set or any req is high, the block SHALL grant one port. Next cycle it SHALL drive mem_enable high for exactly one cycle and enter S_WAIT.
REQ-009 Latency: a req in cycle N with S_IDLE and no competing request SHALL produce mem_enable high in cycle N+1.
REQ-010 Tie-break: when both ports are eligible, the port not granted last SHALL win. The last-grant register SHALL reset to fetch, so data wins the first tie.
REQ-011 A fetch grant SHALL drive mem_we=0 and mem_be=all ones. A data grant SHALL drive the latched we, be and wdata. mem_addr SHALL be the latched address.
REQ-012 mem_addr, mem_we, mem_wdata and mem_be SHALL hold stable from the mem_enable cycle until the transaction completes.
REQ-013 In S_WAIT, mem_done SHALL be honoured only from the cycle after mem_enable; mem_done coincident with mem_enable SHALL be ignored.
REQ-014 On mem_done in cycle M, the block SHALL:
- pulse the granted port's done in cycle M+1;
- capture mem_rdata into that port's rdata;
- clear its pending and in-flight state;
- return to S_IDLE.
The earliest next mem_enable SHALL be cycle M+2.
REQ-015 On a store completion, data_rdata SHALL keep its previous value.
REQ-016 fetch_rdata and data_rdata SHALL hold their values until the next completion on the same port.
REQ-017 Timeout: a counter SHALL clear on grant and increment each S_WAIT cycle. If it reaches TIMEOUT_CYCLES without mem_done, the block SHALL:
- pulse the granted port's done together with err;
- leave that port's rdata unchanged;
- return to S_IDLE.
REQ-018 mem_done in S_IDLE (late or spurious) SHALL be ignored.
REQ-019 A req arriving in the same cycle as the other port's completion SHALL be latched normally and arbitrated in the following S_IDLE.
REQ-020 done pulses SHALL never be asserted for both ports in the same cycle.

Reset
REQ-021 With reset_n low at a clock edge, the block SHALL force:
- state to S_IDLE;
- all pending, in-flight and last-grant state to reset values, discarding any in-flight transaction;
- the timeout counter to 0.
REQ-022 Reset values of all outputs SHALL be 0: done, busy, err, mem_enable, mem_we, mem_addr, mem_wdata, mem_be, fetch_rdata, data_rdata.
REQ-023 mem_done arriving after reset release, for a transaction issued before reset, SHALL be ignored.

Verification
REQ-024 Single fetch: fetch_req at cycle 0 with addr 0x100; mem_done at cycle 3 with rdata 0x00000013. Required: mem_enable at cycle 1 with mem_we=0 and mem_be=0xF; fetch_done and fetch_rdata=0x13 at cycle 4; fetch_busy high from cycle 1 through 4 and low at cycle 5.
REQ-025 Simultaneous requests: fetch_req and data_req (store 0xDEADBEEF to 0x200, be=0x3) in the same cycle after reset. Required: data granted first with mem_we=1 and mem_be=0x3; fetch granted second; a further tie grants data again.
REQ-026 Overrun: a second fetch_req with addr 0x300 while fetch_busy=1. Required: it is ignored; exactly one mem_enable, with the original address.
REQ-027 Timeout: TIMEOUT_CYCLES=4, data load, mem_done never arrives. Required: data_done and err pulse together on the 4th S_WAIT cycle; data_rdata unchanged; a late mem_done is ignored.
REQ-028 Reset mid-operation: reset_n low for one cycle while in S_WAIT. Required: all outputs 0; a subsequent mem_done produces no done pulse; a fresh fetch_req is served normally.
